// File: rtl/instr_encoder_pkg.sv
// Shared RV64I encoding constants for the instruction encoder.
// These values must stay identical to the ones the decoder uses.
package instr_encoder_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: builds the 32-bit word for one field tuple
// and reports whether its immediate is representable in the chosen format.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    // Immediate range checks compare against the sign-extended low field.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (fmt)
            FMT_R: begin
                word  = {funct7, rs2, rs1, funct3, rd, opcode};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {imm[11:0], rs1, funct3, rd, opcode};
                legal = (imm == {{20{imm[11]}}, imm[11:0]});
            end
            FMT_S: begin
                word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                legal = (imm == {{20{imm[11]}}, imm[11:0]});
            end
            FMT_B: begin
                word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                legal = !imm[0] && (imm == {{19{imm[12]}}, imm[12:0]});
            end
            FMT_U: begin
                word  = {imm[31:12], rd, opcode};
                legal = (imm[11:0] == 12'd0);
            end
            FMT_J: begin
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                legal = !imm[0] && (imm == {{11{imm[20]}}, imm[20:0]});
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: one-entry output register behind a
// valid/ready handshake, tagging each emitted word with its memory address.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    logic [31:0] packedWord;
    logic        packedLegal;
    logic        inFire;
    logic        outFire;

    instr_pack u_pack (
        .fmt    (fmt),
        .opcode (opcode),
        .rd     (rd),
        .rs1    (rs1),
        .rs2    (rs2),
        .funct3 (funct3),
        .funct7 (funct7),
        .imm    (imm),
        .word   (packedWord),
        .legal  (packedLegal)
    );

    assign in_ready = !clr && (!out_valid || out_ready);
    assign inFire   = in_valid && in_ready;
    assign outFire  = out_valid && out_ready;

    // Illegal tuples are swallowed: they complete the handshake but only set err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= BaseAddr;
            err       <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
            out_addr  <= BaseAddr;
            err       <= 1'b0;
        end else begin
            if (outFire) begin
                out_addr <= out_addr + ADDR_W'(1);
            end
            if (inFire) begin
                if (packedLegal) begin
                    out_valid <= 1'b1;
                    out_instr <= packedWord;
                end else begin
                    out_valid <= 1'b0;
                    err       <= 1'b1;
                end
            end else if (outFire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: golden encodings, back-pressure,
// illegal immediates, address wrap (second narrow instance), clr and async reset.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;
    logic        err;

    logic        inReadyW;
    logic        outValidW;
    logic [31:0] outInstrW;
    logic [1:0]  outAddrW;
    logic        errW;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err)
    );

    // Narrow-address copy sharing all inputs, used to observe counter wrap.
    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dutWrap (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (inReadyW),
        .fmt       (fmt),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (outValidW),
        .out_ready (out_ready),
        .out_instr (outInstrW),
        .out_addr  (outAddrW),
        .err       (errW)
    );

    logic [2:0]  gFmt [6] = '{FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J};
    logic [6:0]  gOpc [6] = '{OPC_OP, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_JAL};
    logic [4:0]  gRd  [6] = '{5'd3, 5'd5, 5'd31, 5'd31, 5'd10, 5'd1};
    logic [4:0]  gRs1 [6] = '{5'd1, 5'd4, 5'd6, 5'd8, 5'd0, 5'd0};
    logic [4:0]  gRs2 [6] = '{5'd2, 5'd0, 5'd7, 5'd9, 5'd0, 5'd0};
    logic [2:0]  gF3  [6] = '{3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
    logic [31:0] gImm [6] = '{32'd0, 32'd16, 32'd8, 32'hFFFF_F7FE, 32'h1234_5000, 32'd8};
    logic [31:0] gExp [6] = '{32'h0020_81B3, 32'h0102_0293, 32'h0073_2423,
                              32'hFE94_0F63, 32'h1234_5537, 32'h0080_00EF};

    // Independent decoder used to check that emitted words round-trip.
    function automatic logic [31:0] decodeImm(input logic [2:0] f, input logic [31:0] w);
        case (f)
            FMT_I:   return {{20{w[31]}}, w[31:20]};
            FMT_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            FMT_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            FMT_U:   return {w[31:12], 12'd0};
            FMT_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                                 input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] im);
        fmt      = f;
        opcode   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        funct3   = f3;
        funct7   = f7;
        imm      = im;
        in_valid = 1'b1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseClear();
        clr = 1'b1;
        stepClock();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_instr", out_instr, 32'd0);
        checkOutput("rst_addr", 32'(out_addr), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(in_ready), 32'd1);

        $display("[TB] golden encodings");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(gFmt[i], gOpc[i], gRd[i], gRs1[i], gRs2[i], gF3[i], 7'd0, gImm[i]);
            stepClock();
            checkOutput("gold_valid", 32'(out_valid), 32'd1);
            checkOutput("gold_instr", out_instr, gExp[i]);
            checkOutput("gold_addr", 32'(out_addr), 32'(i));
            if (gFmt[i] != FMT_R)
                checkOutput("gold_roundtrip", decodeImm(gFmt[i], out_instr), gImm[i]);
        end
        in_valid = 1'b0;
        stepClock();
        checkOutput("gold_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("gold_drain_addr", 32'(out_addr), 32'd6);

        $display("[TB] back-pressure");
        pulseClear();
        checkOutput("clr_addr", 32'(out_addr), 32'd0);
        out_ready = 1'b0;
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        stepClock();
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        #1;
        for (int c = 0; c < 3; c++) begin
            checkOutput("bp_hold_instr", out_instr, 32'h0010_0093);
            checkOutput("bp_hold_addr", 32'(out_addr), 32'd0);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            stepClock();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
        stepClock();
        in_valid = 1'b0;
        checkOutput("bp_second_instr", out_instr, 32'h0020_0113);
        checkOutput("bp_second_addr", 32'(out_addr), 32'd1);
        stepClock();
        checkOutput("bp_drain_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_drain_addr", 32'(out_addr), 32'd2);

        $display("[TB] illegal immediates");
        pulseClear();
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        stepClock();
        checkOutput("ill_i_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_i_err", 32'(err), 32'd1);
        applyStimulus(FMT_B, OPC_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        stepClock();
        checkOutput("ill_b_valid", 32'(out_valid), 32'd0);
        applyStimulus(FMT_U, OPC_LUI, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1001);
        stepClock();
        checkOutput("ill_u_valid", 32'(out_valid), 32'd0);
        applyStimulus(3'd7, OPC_OP, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        stepClock();
        checkOutput("ill_fmt_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_addr_kept", 32'(out_addr), 32'd0);
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd5, 5'd4, 5'd0, 3'd0, 7'd0, 32'd16);
        stepClock();
        checkOutput("ill_next_instr", out_instr, 32'h0102_0293);
        checkOutput("ill_next_addr", 32'(out_addr), 32'd0);
        checkOutput("ill_err_sticky", 32'(err), 32'd1);
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd5, 5'd4, 5'd0, 3'd0, 7'd0, 32'hFFFF_F7FF);
        stepClock();
        in_valid = 1'b0;
        checkOutput("ill_fire_valid", 32'(out_valid), 32'd0);
        checkOutput("ill_fire_addr", 32'(out_addr), 32'd1);
        pulseClear();
        checkOutput("clr_err", 32'(err), 32'd0);

        $display("[TB] address wrap");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(FMT_R, OPC_OP, 5'(i), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            stepClock();
            checkOutput("wrap_addr", 32'(outAddrW), 32'(i % 4));
        end
        in_valid = 1'b0;
        stepClock();
        checkOutput("wrap_final", 32'(outAddrW), 32'd1);

        $display("[TB] reset and clr mid-stream");
        applyStimulus(FMT_J, OPC_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        stepClock();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        stepClock();
        checkOutput("mid_pending", 32'(out_valid), 32'd1);
        checkOutput("mid_pending_addr", 32'(out_addr), 32'd5);
        #1 rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_addr", 32'(out_addr), 32'd0);
        checkOutput("mid_rst_instr", out_instr, 32'd0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        stepClock();
        applyStimulus(FMT_I, OPC_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        clr = 1'b1;
        #1;
        checkOutput("clr_blocks_ready", 32'(in_ready), 32'd0);
        stepClock();
        clr      = 1'b0;
        in_valid = 1'b0;
        checkOutput("clr_no_accept", 32'(out_valid), 32'd0);
        stepClock();
        checkOutput("clr_no_late_word", 32'(out_valid), 32'd0);
        checkOutput("clr_addr_base", 32'(out_addr), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV64I instruction encoder: the inverse of the core's instruction decoder. It accepts decoded fields (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) over a valid/ready handshake, range-checks the immediate, and packs the fields into a 32-bit instruction word. Each word is emitted with a sequential instruction-memory word address. It sits between the test/boot program generator and instruction memory, and produces images the decoder must round-trip exactly.

## Interface
Parameters:
- ADDR_W, 10, width of the output word address; the counter wraps at 2^ADDR_W
- BASE_ADDR, 0, address loaded on reset and on clr

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous: address counter to BASE_ADDR, err cleared, pending output discarded
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple this cycle
- fmt  input  3  0=R 1=I 2=S 3=B 4=U 5=J; 6 and 7 are illegal
- opcode  input  7  copied into bits 6:0
- rd, rs1, rs2  input  5 each  register indices
- funct3  input  3; funct7  input  7
- imm  input  32  signed byte offset or U value, unshifted
- out_valid  output  1  encoded word valid
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  word address of out_instr
- err  output  1  sticky: at least one tuple was dropped since reset or clr

## Operation
- Packing (imm as given):
  - R: {funct7,rs2,rs1,funct3,rd,opcode}
  - I: {imm[11:0],rs1,funct3,rd,opcode}
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}
  - U: {imm[31:12],rd,opcode}
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}
- Fields unused by a format are ignored. Shift-immediates carry funct7 in imm[11:5] (SRAI: imm=0x400|shamt).
- Legality checks:
  - I/S: imm equals sign-extension of imm[11:0].
  - B: imm[0]=0 and imm equals sign-extension of imm[12:0].
  - J: imm[0]=0 and imm equals sign-extension of imm[20:0].
  - U: imm[11:0]=0.
  - R: always legal. fmt 6/7: always illegal.
- An illegal tuple is consumed (handshake completes), no word is emitted, err is set, and the address does not advance.
- The address counter advances by 1, mod 2^ADDR_W, only on an output handshake (out_valid and out_ready).

## Timing
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0. in_ready=1 after reset and while rst is deasserted with no pending word.
- One-entry output register: in_ready = !clr && (!out_valid || out_ready). A full pipelined stream is one word per cycle.
- Latency: tuple accepted at edge N → out_valid/out_instr valid after edge N. out_addr shows the address the word will be written to.
- While out_valid=1 && out_ready=0: out_instr and out_addr are held stable and in_ready=0.
- Simultaneous output handshake and legal input: register reloads, out_valid stays 1, out_addr increments.
- Simultaneous output handshake and illegal input: out_valid falls to 0, address increments, err sets.
- clr has priority over everything in its cycle: no input is accepted, out_valid→0, address→BASE_ADDR, err→0.
- rst mid-stream: the pending word is lost immediately (asynchronous); all outputs go to their reset values.

## Structure
- Shared package: fmt constants FMT_R..FMT_J and the RV64I opcode constants (LOAD, OP_IMM, STORE, OP, BRANCH, JALR, JAL, LUI, AUIPC, SYSTEM), so they match the decoder.
- One combinational sub-module, instr_pack: fields in; word and legal out. The top holds the output register, the handshake and the address counter.

## Test plan
- Golden words, fmt/fields → out_instr:
  - R add x3,x1,x2 → 0x002081B3
  - I addi x5,x4,16 → 0x01020293
  - S sw x7,8(x6) → 0x00732423
  - B beq x8,x9,imm=-2050 → 0xFE940F63
  - U lui x10,0x12345000 → 0x12345537
  - J jal x1,8 → 0x008000EF
  - Addresses 0..5; each word is fed back through the decoder and the fields match.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 → word held, in_ready=0, no tuple lost. After release, two words are emitted at addresses 0 and 1.
- Illegal immediates: I imm=2048, B imm=3, U imm=0x1001, fmt=7 → no out_valid, err=1, next legal word at the unchanged address. clr → err=0.
- Wrap: ADDR_W=2, 5 legal tuples → out_addr 0,1,2,3,0.
- Reset/clr mid-stream: rst pulsed while out_valid=1 && out_ready=0 → out_valid=0 at once, out_addr=BASE_ADDR. clr in the same cycle as in_valid → tuple not accepted.
